// File: rtl/id_ex_reg_if.sv
// Decode-to-execute pipeline boundary: decode-slot fields, stall/flush controls
// and the registered execute-stage fields presented downstream.
interface id_ex_reg_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 6,
  parameter int LD_TYPE_WIDTH = 3
);
  logic                     Decode_Valid;
  logic [DATA_WIDTH-1:0]    Decode_Pc;
  logic [DATA_WIDTH-1:0]    Decode_Rs1Data;
  logic [DATA_WIDTH-1:0]    Decode_Rs2Data;
  logic [DATA_WIDTH-1:0]    Decode_Rs3Data;
  logic [DATA_WIDTH-1:0]    Decode_Imm;
  logic [RF_ADDR_WIDTH-1:0] Decode_RdAddr;
  logic                     Decode_WbRdEn;
  logic [LD_TYPE_WIDTH-1:0] Decode_LdType;

  logic                     Hazard_StallReq;
  logic                     Ex_StallReq;
  logic                     Flush;

  logic                     IDEX_Valid;
  logic [DATA_WIDTH-1:0]    IDEX_Pc;
  logic [DATA_WIDTH-1:0]    IDEX_Rs1Data;
  logic [DATA_WIDTH-1:0]    IDEX_Rs2Data;
  logic [DATA_WIDTH-1:0]    IDEX_Rs3Data;
  logic [DATA_WIDTH-1:0]    IDEX_Imm;
  logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr;
  logic                     IDEX_WbRdEn;
  logic [LD_TYPE_WIDTH-1:0] IDEX_LdType;
  logic                     IDEX_UpstreamStall;
  logic [15:0]              IDEX_BubbleCnt;

  // Decode side of the boundary: drives the slot and controls, consumes IDEX.
  modport master (
    output Decode_Valid, Decode_Pc, Decode_Rs1Data, Decode_Rs2Data, Decode_Rs3Data,
           Decode_Imm, Decode_RdAddr, Decode_WbRdEn, Decode_LdType,
           Hazard_StallReq, Ex_StallReq, Flush,
    input  IDEX_Valid, IDEX_Pc, IDEX_Rs1Data, IDEX_Rs2Data, IDEX_Rs3Data,
           IDEX_Imm, IDEX_RdAddr, IDEX_WbRdEn, IDEX_LdType,
           IDEX_UpstreamStall, IDEX_BubbleCnt
  );

  modport slave (
    input  Decode_Valid, Decode_Pc, Decode_Rs1Data, Decode_Rs2Data, Decode_Rs3Data,
           Decode_Imm, Decode_RdAddr, Decode_WbRdEn, Decode_LdType,
           Hazard_StallReq, Ex_StallReq, Flush,
    output IDEX_Valid, IDEX_Pc, IDEX_Rs1Data, IDEX_Rs2Data, IDEX_Rs3Data,
           IDEX_Imm, IDEX_RdAddr, IDEX_WbRdEn, IDEX_LdType,
           IDEX_UpstreamStall, IDEX_BubbleCnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: load, hold, bubble or flush the execute slot each
// cycle, and count hazard bubbles with a saturating 16-bit counter.
module id_ex_reg #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 6,
  parameter int LD_TYPE_WIDTH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_reg_if.slave   bus
);

  localparam logic [LD_TYPE_WIDTH-1:0] LD_XXX = '0;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_HAZARD,
    ACT_IDLE,
    ACT_LOAD
  } action_e;

  typedef struct packed {
    logic                     valid;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    rs1Data;
    logic [DATA_WIDTH-1:0]    rs2Data;
    logic [DATA_WIDTH-1:0]    rs3Data;
    logic [DATA_WIDTH-1:0]    imm;
    logic [RF_ADDR_WIDTH-1:0] rdAddr;
    logic                     wbRdEn;
    logic [LD_TYPE_WIDTH-1:0] ldType;
  } stage_t;

  action_e     action;
  stage_t      stageQ;
  stage_t      decodeSlot;
  stage_t      bubbleSlot;
  logic [15:0] bubbleCntQ;

  // Exactly one action per cycle, in strict priority order.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    action = ACT_LOAD;
    if (!rst_n)                    action = ACT_RESET;
    else if (bus.Flush)            action = ACT_FLUSH;
    else if (bus.Ex_StallReq)      action = ACT_HOLD;
    else if (bus.Hazard_StallReq)  action = ACT_HAZARD;
    else if (!bus.Decode_Valid)    action = ACT_IDLE;
  end

  always_comb begin
    decodeSlot         = '0;
    decodeSlot.valid   = 1'b1;
    decodeSlot.pc      = bus.Decode_Pc;
    decodeSlot.rs1Data = bus.Decode_Rs1Data;
    decodeSlot.rs2Data = bus.Decode_Rs2Data;
    decodeSlot.rs3Data = bus.Decode_Rs3Data;
    decodeSlot.imm     = bus.Decode_Imm;
    decodeSlot.rdAddr  = bus.Decode_RdAddr;
    decodeSlot.wbRdEn  = bus.Decode_WbRdEn;
    decodeSlot.ldType  = bus.Decode_LdType;
  end

  // A killed slot carries no writeback and no load so forwarding can never match it.
  always_comb begin
    bubbleSlot        = '0;
    bubbleSlot.ldType = LD_XXX;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stageQ     <= bubbleSlot;
      bubbleCntQ <= '0;
    end else begin
      unique case (action)
        ACT_LOAD: stageQ <= decodeSlot;
        ACT_HOLD: stageQ <= stageQ;
        ACT_HAZARD: begin
          stageQ <= bubbleSlot;
          if (bubbleCntQ != 16'hFFFF) bubbleCntQ <= bubbleCntQ + 16'd1;
        end
        ACT_FLUSH, ACT_IDLE, ACT_RESET: stageQ <= bubbleSlot;
        default: stageQ <= bubbleSlot;
      endcase
    end
  end

  assign bus.IDEX_Valid   = stageQ.valid;
  assign bus.IDEX_Pc      = stageQ.pc;
  assign bus.IDEX_Rs1Data = stageQ.rs1Data;
  assign bus.IDEX_Rs2Data = stageQ.rs2Data;
  assign bus.IDEX_Rs3Data = stageQ.rs3Data;
  assign bus.IDEX_Imm     = stageQ.imm;
  assign bus.IDEX_RdAddr  = stageQ.rdAddr;
  assign bus.IDEX_WbRdEn  = stageQ.wbRdEn;
  assign bus.IDEX_LdType  = stageQ.ldType;
  assign bus.IDEX_BubbleCnt = bubbleCntQ;

  // Flush redirects fetch anyway, so it suppresses the hold request; reset does not gate it.
  assign bus.IDEX_UpstreamStall = (bus.Hazard_StallReq | bus.Ex_StallReq) & ~bus.Flush;

  bubbleNeverWrites: assert property (
    @(posedge clk) disable iff (!rst_n)
      !bus.IDEX_Valid |-> (!bus.IDEX_WbRdEn && bus.IDEX_LdType == LD_XXX)
  );

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized scoreboard bench for id_ex_reg: a driver predicts each next IDEX
// state from the action-priority rules, a monitor pops and compares every cycle.
module tb_id_ex_reg;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int LW = 3;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc, rs1, rs2, rs3, imm;
    logic [AW-1:0] rd;
    logic          wb;
    logic [LW-1:0] ld;
  } dec_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc, rs1, rs2, rs3, imm;
    logic [AW-1:0] rd;
    logic          wb;
    logic [LW-1:0] ld;
    logic [15:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_reg_if #(.DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW), .LD_TYPE_WIDTH(LW)) bus ();

  id_ex_reg #(.DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW), .LD_TYPE_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t expQ[$];
  exp_t model = '0;
  int   nChecks = 0;
  int   nFail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    nChecks++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  function automatic dec_t randDec();
    dec_t d;
    logic [31:0] r;
    d.valid = 1'b1;
    d.pc    = $urandom;
    d.rs1   = $urandom;
    d.rs2   = $urandom;
    d.rs3   = $urandom;
    d.imm   = $urandom;
    r       = $urandom;
    d.rd    = r[AW-1:0];
    d.wb    = r[8];
    d.ld    = r[12 +: LW];
    return d;
  endfunction

  // One cycle of stimulus: apply inputs, check the combinational stall, predict the next state.
  task automatic drive(input dec_t d, input logic haz, input logic ex, input logic fl, input logic rn);
    exp_t nxt;
    @(negedge clk);
    bus.Decode_Valid    = d.valid;
    bus.Decode_Pc       = d.pc;
    bus.Decode_Rs1Data  = d.rs1;
    bus.Decode_Rs2Data  = d.rs2;
    bus.Decode_Rs3Data  = d.rs3;
    bus.Decode_Imm      = d.imm;
    bus.Decode_RdAddr   = d.rd;
    bus.Decode_WbRdEn   = d.wb;
    bus.Decode_LdType   = d.ld;
    bus.Hazard_StallReq = haz;
    bus.Ex_StallReq     = ex;
    bus.Flush           = fl;
    rst_n               = rn;
    #1;
    check("upstreamStall", bus.IDEX_UpstreamStall, (haz | ex) & ~fl);

    nxt = model;
    if (!rn) begin
      nxt = '0;
    end else if (fl) begin
      nxt = '0;
      nxt.cnt = model.cnt;
    end else if (ex) begin
      nxt = model;
    end else if (haz) begin
      nxt = '0;
      nxt.cnt = (model.cnt == 16'hFFFF) ? 16'hFFFF : model.cnt + 16'd1;
    end else if (!d.valid) begin
      nxt = '0;
      nxt.cnt = model.cnt;
    end else begin
      nxt = {1'b1, d.pc, d.rs1, d.rs2, d.rs3, d.imm, d.rd, d.wb, d.ld, model.cnt};
    end
    model = nxt;
    expQ.push_back(nxt);
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = {bus.IDEX_Valid, bus.IDEX_Pc, bus.IDEX_Rs1Data, bus.IDEX_Rs2Data,
             bus.IDEX_Rs3Data, bus.IDEX_Imm, bus.IDEX_RdAddr, bus.IDEX_WbRdEn,
             bus.IDEX_LdType, bus.IDEX_BubbleCnt};
        check("ctrl", {a.valid, a.wb, a.ld, a.rd}, {e.valid, e.wb, e.ld, e.rd});
        check("data", {a.pc, a.rs1, a.rs2, a.rs3, a.imm}, {e.pc, e.rs1, e.rs2, e.rs3, e.imm});
        check("bubbleCnt", a.cnt, e.cnt);
      end
    end
  end

  initial begin : stimulus
    dec_t d;
    logic haz, ex, fl, rn;

    rst_n = 1'b0;
    bus.Decode_Valid = 1'b0;
    bus.Decode_Pc = '0;
    bus.Decode_Rs1Data = '0;
    bus.Decode_Rs2Data = '0;
    bus.Decode_Rs3Data = '0;
    bus.Decode_Imm = '0;
    bus.Decode_RdAddr = '0;
    bus.Decode_WbRdEn = 1'b0;
    bus.Decode_LdType = '0;
    bus.Hazard_StallReq = 1'b0;
    bus.Ex_StallReq = 1'b0;
    bus.Flush = 1'b0;

    // Reset with noisy controls asserted.
    drive(randDec(), 1'b1, 1'b1, 1'b1, 1'b0);
    drive(randDec(), 1'b0, 1'b0, 1'b0, 1'b0);

    // Simple load.
    d = '0;
    d.valid = 1'b1;
    d.pc    = 32'h100;
    d.rs1   = 32'hA;
    d.rd    = 6'd5;
    d.wb    = 1'b1;
    drive(d, 1'b0, 1'b0, 1'b0, 1'b1);

    // Load-use bubble, then back-to-back loads.
    drive(randDec(), 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) drive(randDec(), 1'b0, 1'b0, 1'b0, 1'b1);

    // Three-cycle hold with changing decode inputs, then resume.
    repeat (3) drive(randDec(), 1'b0, 1'b1, 1'b0, 1'b1);
    drive(randDec(), 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush overrides every stall.
    drive(randDec(), 1'b1, 1'b1, 1'b1, 1'b1);
    drive(randDec(), 1'b0, 1'b0, 1'b0, 1'b1);

    // Hazard bubble during a hold must not count; idle slot bubbles must not count.
    drive(randDec(), 1'b1, 1'b1, 1'b0, 1'b1);
    d = randDec();
    d.valid = 1'b0;
    drive(d, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized mix of all actions.
    repeat (600) begin
      d       = randDec();
      d.valid = ($urandom_range(3) != 0);
      rn      = ($urandom_range(99) >= 2);
      fl      = ($urandom_range(7) == 0);
      ex      = ($urandom_range(4) == 0);
      haz     = ($urandom_range(3) == 0);
      drive(d, haz, ex, fl, rn);
    end

    // Reset in the middle of a hold with valid contents.
    drive(randDec(), 1'b0, 1'b0, 1'b0, 1'b1);
    drive(randDec(), 1'b0, 1'b1, 1'b0, 1'b1);
    drive(randDec(), 1'b0, 1'b1, 1'b0, 1'b0);
    drive(randDec(), 1'b0, 1'b1, 1'b0, 1'b1);
    drive(randDec(), 1'b0, 1'b0, 1'b0, 1'b1);

    // Saturation: 0xFFFE bubbles from zero, then more that must stick at 0xFFFF.
    drive(randDec(), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (16'hFFFE) drive(randDec(), 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) drive(randDec(), 1'b1, 1'b0, 1'b0, 1'b1);
    drive(randDec(), 1'b0, 1'b1, 1'b0, 1'b1);
    drive(randDec(), 1'b0, 1'b0, 1'b0, 1'b1);
    drive(randDec(), 1'b1, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    check("queueDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
